// File: rtl/mips_bus_arbiter.sv
// ============================================================================
// Module   : mips_bus_arbiter
// Purpose  : Arbitrates instruction reads, data reads and write-buffer drains
//            onto a single Avalon-MM master port, with write-starvation guard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_bus_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  // instruction side
  input  logic        i_read,
  input  logic [31:0] i_address,
  output logic [31:0] i_readdata,
  output logic        i_valid,
  // data side
  input  logic        d_read,
  input  logic [31:0] d_address,
  output logic [31:0] d_readdata,
  output logic        d_valid,
  // write buffer head
  input  logic        wb_req,
  input  logic        wb_conflict,
  input  logic [31:0] wb_address,
  input  logic [31:0] wb_writedata,
  input  logic [3:0]  wb_byteenable,
  output logic        wb_pop,
  // Avalon-MM master
  output logic [31:0] mem_address,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        waitrequest,
  input  logic [31:0] mem_readdata,
  output logic        busy
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INSTR_RD = 2'd1,
    DATA_RD  = 2'd2,
    WB_WR    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic             grant_i;
  logic             grant_d;
  logic             grant_w;
  logic             done;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [3:0]       be_q;

  // Only IDLE grants; every granted state returns to IDLE on completion.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    grant_w    = 1'b0;
    case (state)
      IDLE: begin
        if (wb_req && (wb_conflict || starve_cnt == CNT_MAX)) begin
          grant_w    = 1'b1;
          state_next = WB_WR;
        end else if (i_read) begin
          grant_i    = 1'b1;
          state_next = INSTR_RD;
        end else if (d_read) begin
          grant_d    = 1'b1;
          state_next = DATA_RD;
        end else if (wb_req) begin
          grant_w    = 1'b1;
          state_next = WB_WR;
        end
      end
      INSTR_RD, DATA_RD, WB_WR: begin
        if (!waitrequest) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign done = (state != IDLE) && !waitrequest;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Write-starvation counter: saturates, cleared by a write grant or an empty buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (!wb_req || grant_w) begin
        starve_cnt <= '0;
      end else if ((grant_i || grant_d) && starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else if (grant_i) begin
      addr_q  <= i_address;
      wdata_q <= '0;
      be_q    <= 4'hF;
    end else if (grant_d) begin
      addr_q  <= d_address;
      wdata_q <= '0;
      be_q    <= 4'hF;
    end else if (grant_w) begin
      addr_q  <= wb_address;
      wdata_q <= wb_writedata;
      be_q    <= wb_byteenable;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_readdata <= '0;
      d_readdata <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
    end else begin
      i_valid <= done && (state == INSTR_RD);
      d_valid <= done && (state == DATA_RD);
      if (done && state == INSTR_RD) i_readdata <= mem_readdata;
      if (done && state == DATA_RD)  d_readdata <= mem_readdata;
    end
  end

  // Commands decode from the state register so an async reset drops them at once.
  assign mem_read       = (state == INSTR_RD) || (state == DATA_RD);
  assign mem_write      = (state == WB_WR);
  assign wb_pop         = (state == WB_WR) && !waitrequest;
  assign busy           = (state != IDLE);
  assign mem_address    = addr_q;
  assign mem_writedata  = wdata_q;
  assign mem_byteenable = be_q;

endmodule

`default_nettype wire

// File: tb/tb_mips_bus_arbiter.sv
// ============================================================================
// Module   : tb_mips_bus_arbiter
// Purpose  : Directed self-checking bench for mips_bus_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read, d_read, wb_req, wb_conflict, waitrequest;
  logic [31:0] i_address, d_address, wb_address, wb_writedata, mem_readdata;
  logic [3:0]  wb_byteenable;
  logic [31:0] i_readdata, d_readdata, mem_address, mem_writedata;
  logic [3:0]  mem_byteenable;
  logic        i_valid, d_valid, wb_pop, mem_read, mem_write, busy;

  int total = 0;
  int bad   = 0;

  mips_bus_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_valid(i_valid),
    .d_read(d_read), .d_address(d_address), .d_readdata(d_readdata), .d_valid(d_valid),
    .wb_req(wb_req), .wb_conflict(wb_conflict), .wb_address(wb_address),
    .wb_writedata(wb_writedata), .wb_byteenable(wb_byteenable), .wb_pop(wb_pop),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_byteenable(mem_byteenable), .mem_read(mem_read), .mem_write(mem_write),
    .waitrequest(waitrequest), .mem_readdata(mem_readdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0;
    i_read = 0; d_read = 0; wb_req = 0; wb_conflict = 0; waitrequest = 0;
    i_address = 0; d_address = 0; wb_address = 0; wb_writedata = 0;
    wb_byteenable = 0; mem_readdata = 0;

    // reset state
    step(); step();
    chk("rst_mem_read", 32'(mem_read), 32'd0);
    chk("rst_mem_write", 32'(mem_write), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valids", {30'd0, i_valid, d_valid}, 32'd0);
    chk("rst_wb_pop", 32'(wb_pop), 32'd0);
    chk("rst_i_readdata", i_readdata, 32'd0);
    chk("rst_d_readdata", d_readdata, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    chk("rst_mem_be", 32'(mem_byteenable), 32'd0);
    rst = 1'b1;

    // single instruction fetch, zero wait states
    i_read = 1; i_address = 32'hBFC0_0000; mem_readdata = 32'h2402_0005;
    step();
    chk("if_mem_read", 32'(mem_read), 32'd1);
    chk("if_mem_write", 32'(mem_write), 32'd0);
    chk("if_address", mem_address, 32'hBFC0_0000);
    chk("if_be", 32'(mem_byteenable), 32'hF);
    chk("if_busy", 32'(busy), 32'd1);
    chk("if_valid_early", 32'(i_valid), 32'd0);
    step();
    chk("if_valid", 32'(i_valid), 32'd1);
    chk("if_readdata", i_readdata, 32'h2402_0005);
    chk("if_mem_read_off", 32'(mem_read), 32'd0);
    i_read = 0;
    step();
    chk("if_valid_pulse", 32'(i_valid), 32'd0);
    chk("if_idle", 32'(busy), 32'd0);

    // simultaneous instruction and data read
    i_read = 1; i_address = 32'h0000_0100; d_read = 1; d_address = 32'h0000_0200;
    mem_readdata = 32'h1111_1111;
    step();
    chk("both_first_addr", mem_address, 32'h0000_0100);
    chk("both_first_rw", {30'd0, mem_read, mem_write}, 32'b10);
    step();
    chk("both_i_valid", 32'(i_valid), 32'd1);
    chk("both_i_data", i_readdata, 32'h1111_1111);
    chk("both_gap_rw", {30'd0, mem_read, mem_write}, 32'b00);
    i_read = 0; mem_readdata = 32'h2222_2222;
    step();
    chk("both_second_addr", mem_address, 32'h0000_0200);
    chk("both_second_rw", {30'd0, mem_read, mem_write}, 32'b10);
    step();
    chk("both_d_valid", 32'(d_valid), 32'd1);
    chk("both_d_data", d_readdata, 32'h2222_2222);
    chk("both_i_hold", i_readdata, 32'h1111_1111);
    chk("both_i_valid_off", 32'(i_valid), 32'd0);
    d_read = 0;
    step();

    // write-buffer conflict beats a data read
    wb_req = 1; wb_conflict = 1; d_read = 1; d_address = 32'h0000_0300;
    wb_address = 32'h0000_1000; wb_writedata = 32'hCAFE_F00D; wb_byteenable = 4'b0011;
    mem_readdata = 32'h3333_3333;
    step();
    chk("conf_rw", {30'd0, mem_read, mem_write}, 32'b01);
    chk("conf_addr", mem_address, 32'h0000_1000);
    chk("conf_wdata", mem_writedata, 32'hCAFE_F00D);
    chk("conf_be", 32'(mem_byteenable), 32'h3);
    chk("conf_pop", 32'(wb_pop), 32'd1);
    wb_req = 0; wb_conflict = 0;
    step();
    chk("conf_pop_off", 32'(wb_pop), 32'd0);
    chk("conf_gap_busy", 32'(busy), 32'd0);
    step();
    chk("conf_dr_addr", mem_address, 32'h0000_0300);
    chk("conf_dr_be", 32'(mem_byteenable), 32'hF);
    chk("conf_dr_read", 32'(mem_read), 32'd1);
    step();
    chk("conf_d_valid", 32'(d_valid), 32'd1);
    chk("conf_d_data", d_readdata, 32'h3333_3333);
    d_read = 0;
    step();

    // data read with three wait states and a moving address
    d_read = 1; d_address = 32'h0000_0400; waitrequest = 1; mem_readdata = 32'h4444_4444;
    step();
    d_address = 32'h0000_0500;
    step();
    chk("wait_addr_hold", mem_address, 32'h0000_0400);
    chk("wait_no_valid", 32'(d_valid), 32'd0);
    step();
    chk("wait_still_read", 32'(mem_read), 32'd1);
    step();
    waitrequest = 0;
    chk("wait_last_addr", mem_address, 32'h0000_0400);
    chk("wait_done_no_valid", 32'(d_valid), 32'd0);
    step();
    chk("wait_d_valid", 32'(d_valid), 32'd1);
    chk("wait_d_data", d_readdata, 32'h4444_4444);
    d_read = 0;
    step();
    chk("wait_valid_once", 32'(d_valid), 32'd0);

    // starvation guard: four reads then a forced write
    wb_req = 1; wb_conflict = 0; i_read = 1; i_address = 32'h0000_0600;
    wb_address = 32'h0000_2000; wb_writedata = 32'hDEAD_BEEF; wb_byteenable = 4'hF;
    mem_readdata = 32'h6666_6666;
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("starve_rd%0d", k), {30'd0, mem_read, mem_write}, 32'b10);
      step();
      chk($sformatf("starve_iv%0d", k), 32'(i_valid), 32'd1);
    end
    step();
    chk("starve_wr", {30'd0, mem_read, mem_write}, 32'b01);
    chk("starve_wr_addr", mem_address, 32'h0000_2000);
    chk("starve_pop", 32'(wb_pop), 32'd1);
    step();
    chk("starve_pop_off", 32'(wb_pop), 32'd0);
    step();
    chk("starve_resume", {30'd0, mem_read, mem_write}, 32'b10);
    chk("starve_resume_addr", mem_address, 32'h0000_0600);
    i_read = 0; wb_req = 0;
    step();
    step();

    // reset in the middle of a stalled write
    wb_req = 1; wb_address = 32'h0000_3000; wb_writedata = 32'h1234_5678; waitrequest = 1;
    step();
    chk("rstwr_write", 32'(mem_write), 32'd1);
    chk("rstwr_no_pop", 32'(wb_pop), 32'd0);
    step();
    #2;
    rst = 1'b0;
    #1;
    chk("rstwr_write_drop", 32'(mem_write), 32'd0);
    chk("rstwr_busy", 32'(busy), 32'd0);
    chk("rstwr_pop", 32'(wb_pop), 32'd0);
    chk("rstwr_addr_clr", mem_address, 32'd0);
    wb_req = 0; waitrequest = 0; i_read = 1; i_address = 32'h0000_0700;
    mem_readdata = 32'h7777_7777;
    step();
    chk("rstwr_no_grant_in_rst", 32'(mem_read), 32'd0);
    rst = 1'b1;
    chk("rstwr_no_grant_at_release", 32'(mem_read), 32'd0);
    step();
    chk("rstwr_first_grant", 32'(mem_read), 32'd1);
    chk("rstwr_first_addr", mem_address, 32'h0000_0700);
    step();
    chk("rstwr_i_valid", 32'(i_valid), 32'd1);
    chk("rstwr_i_data", i_readdata, 32'h7777_7777);
    i_read = 0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_bus_arbiter.md
MIPS_BUS_ARBITER -- requirements
Module: mips_bus_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, consecutive read grants allowed while write buffer is non-empty before a write is forced.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 i_read  in  1  instruction-side read request; held until i_valid.
REQ-006 i_address  in  32  instruction read address.
REQ-007 i_readdata  out  32  registered instruction read data.
REQ-008 i_valid  out  1  one-cycle pulse; i_readdata valid.
REQ-009 d_read  in  1  data-side read request; held until d_valid.
REQ-010 d_address  in  32  data read address.
REQ-011 d_readdata  out  32  registered data read data.
REQ-012 d_valid  out  1  one-cycle pulse; d_readdata valid.
REQ-013 wb_req  in  1  write buffer non-empty.
REQ-014 wb_conflict  in  1  a pending read address matches a write-buffer entry.
REQ-015 wb_address / wb_writedata / wb_byteenable  in  32/32/4  head-of-buffer write.
REQ-016 wb_pop  out  1  one-cycle pulse; head write accepted by memory.
REQ-017 mem_address / mem_writedata / mem_byteenable  out  32/32/4  Avalon master outputs.
REQ-018 mem_read / mem_write  out  1/1  Avalon commands, never both high.
REQ-019 waitrequest / mem_readdata  in  1/32  Avalon slave responses.
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have states IDLE, INSTR_RD, DATA_RD, WB_WR; IDLE is the only state that grants.
REQ-022 In IDLE, grant priority SHALL be: (1) WB_WR if wb_req && wb_conflict; (2) WB_WR if wb_req && starve_cnt==STARVE_LIMIT; (3) INSTR_RD if i_read; (4) DATA_RD if d_read; (5) WB_WR if wb_req; else stay IDLE.
REQ-023 On grant, the owner's address, writedata, and byteenable SHALL be latched; Avalon outputs SHALL come only from latched values and stay stable until completion.
REQ-024 mem_read SHALL be high exactly in INSTR_RD/DATA_RD; mem_write exactly in WB_WR; mem_byteenable SHALL be 4'b1111 for reads.
REQ-025 Completion: the first cycle in a granted state with waitrequest==0; next state SHALL be IDLE (one idle cycle between transactions).
REQ-026 On read completion, mem_readdata SHALL be registered into the owner's readdata, and the owner's valid SHALL pulse in the following cycle (latency grant-to-valid = 2 cycles with zero wait states).
REQ-027 On write completion, wb_pop SHALL pulse in the completion cycle (combinational on state==WB_WR && !waitrequest).
REQ-028 starve_cnt SHALL be 0..STARVE_LIMIT, increment (saturating) on each read grant while wb_req==1, clear on WB_WR grant, and clear whenever wb_req==0 in IDLE.
REQ-029 A request deasserted mid-transaction SHALL NOT abort it; the transaction completes and valid still pulses.
REQ-030 A read request asserted in the completion cycle SHALL be considered in IDLE on the next cycle, not earlier.
REQ-031 readdata outputs SHALL hold their last value until overwritten by a later completion for the same side.

Reset
REQ-032 While rst==0: state=IDLE, starve_cnt=0, mem_read=mem_write=0, i_valid=d_valid=wb_pop=0, busy=0, i_readdata=d_readdata=0, latched address/data/byteenable=0.
REQ-033 Reset assertion mid-transaction SHALL drop mem_read/mem_write immediately (asynchronously); no valid or pop pulse is produced for the aborted transaction.
REQ-034 The first grant SHALL occur no earlier than the first rising edge after rst deassertion.

Verification
REQ-035 i_read=1, i_address=0xBFC00000, waitrequest=0, mem_readdata=0x24020005 -> mem_read high 1 cycle at 0xBFC00000; i_valid pulses next cycle with i_readdata=0x24020005.
REQ-036 i_read and d_read both high in IDLE -> INSTR_RD granted first; DATA_RD granted after one IDLE cycle; mem_read never overlaps mem_write.
REQ-037 wb_req=1 and i_read=1 held continuously, wb_conflict=0, STARVE_LIMIT=4 -> four instruction reads, then one write with wb_pop pulse, then reads resume.
REQ-038 wb_req=1, wb_conflict=1, d_read=1, wb_address=0x00001000, wb_byteenable=4'b0011 -> WB_WR granted first with those values; DATA_RD follows.
REQ-039 DATA_RD with waitrequest=1 for 3 cycles, d_address changed mid-wait -> mem_address holds the latched address; d_valid pulses once, 1 cycle after waitrequest falls.
REQ-040 rst driven low during WB_WR with waitrequest=1 -> mem_write falls without a clock edge; wb_pop never pulses; busy=0.
